// File: rtl/mmio_gpio_bridge_pkg.sv
// Shared constants and helpers for the memory-mapped GPIO bridge.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mmio_gpio_bridge_pkg;

    // Widest bank the 32-bit data bus can carry.
    localparam int GPIO_MIN_W = 1;
    localparam int GPIO_MAX_W = 32;

    // Byte offsets of the register map. Bits [1:0] of the bus address are
    // dropped before decode. Offset 0x1C and above map to nothing.
    typedef enum logic [4:0] {
        OFF_IN       = 5'h00,
        OFF_OUT      = 5'h04,
        OFF_OUT_SET  = 5'h08,
        OFF_OUT_CLR  = 5'h0C,
        OFF_IRQ_EN   = 5'h10,
        OFF_EDGE_SEL = 5'h14,
        OFF_IRQ_STAT = 5'h18
    } reg_off_t;

    // Expand the four byte enables into a 32-bit bit mask.
    function automatic logic [31:0] byte_mask(input logic [3:0] be);
        return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

endpackage

// File: rtl/mmio_gpio_bridge_debounce.sv
// One input bit: two-flop synchroniser, stability counter, debounced level.
// Latency: a change first sampled at edge k lands in deb at edge k+1+DEB_CYCLES.
// Backpressure: none; free-running every cycle.
//
// Ports: clk/rstn (sync, active-low), sw (async pin), deb (debounced level),
// rise/fall (high in the cycle whose closing edge moves deb up/down).
module gpio_debounce #(
    parameter int DEB_CYCLES = 1000
) (
    input  logic clk,
    input  logic rstn,
    input  logic sw,
    output logic deb,
    output logic rise,
    output logic fall
);

    localparam int CW = (DEB_CYCLES < 1) ? 1 : $clog2(DEB_CYCLES + 1);

    logic          s1;
    logic          s2;
    logic [CW-1:0] cnt;
    logic          accept;

    // The counter has seen s2 differ from deb for DEB_CYCLES consecutive
    // cycles including this one: deb takes s2 at the coming edge.
    assign accept = (s2 != deb) && (cnt == CW'(DEB_CYCLES - 1));

    // Pulses are combinational look-ahead so the interrupt status can be set
    // on the very edge that deb changes.
    assign rise = accept &&  s2;
    assign fall = accept && !s2;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            s1  <= 1'b0;
            s2  <= 1'b0;
            deb <= 1'b0;
            cnt <= '0;
        end else begin
            s1 <= sw;
            s2 <= s1;
            if (s2 == deb) begin
                cnt <= '0;
            end else if (accept) begin
                deb <= s2;
                cnt <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/mmio_gpio_bridge.sv
// Memory-mapped GPIO: debounced input bank, set/clear output bank, edge IRQs.
// Latency: req sampled at edge k; writes land at k, ready/rdata valid in k+1.
// Backpressure: none; accepts a request every cycle, one ready per request.
//
// Ports: clk/rstn (sync, active-low); req/we/addr/wdata bus request;
// rdata/ready response (rdata is 0 outside ready); sw async inputs;
// led = OUT register; irq = |(IRQ_STAT & IRQ_EN).
module mmio_gpio_bridge
    import mmio_gpio_bridge_pkg::*;
#(
    parameter int IN_W       = 16,
    parameter int OUT_W      = 16,
    parameter int DEB_CYCLES = 1000
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             req,
    input  logic [3:0]       we,
    input  logic [4:0]       addr,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata,
    output logic             ready,
    input  logic [IN_W-1:0]  sw,
    output logic [OUT_W-1:0] led,
    output logic             irq
);

    if (IN_W < GPIO_MIN_W || IN_W > GPIO_MAX_W) begin : g_bad_in_w
        $error("IN_W out of range");
    end
    if (OUT_W < GPIO_MIN_W || OUT_W > GPIO_MAX_W) begin : g_bad_out_w
        $error("OUT_W out of range");
    end
    if (DEB_CYCLES < 1) begin : g_bad_deb
        $error("DEB_CYCLES must be at least 1");
    end

    logic [OUT_W-1:0] out_q;
    logic [IN_W-1:0]  irq_en_q;
    logic [IN_W-1:0]  edge_sel_q;
    logic [IN_W-1:0]  irq_stat_q;

    logic [IN_W-1:0]  deb;
    logic [IN_W-1:0]  rise;
    logic [IN_W-1:0]  fall;
    logic [IN_W-1:0]  ev;

    // ---------------------------------------------------------------------
    // Input bank
    // ---------------------------------------------------------------------
    for (genvar i = 0; i < IN_W; i++) begin : g_in
        gpio_debounce #(
            .DEB_CYCLES (DEB_CYCLES)
        ) u_deb (
            .clk  (clk),
            .rstn (rstn),
            .sw   (sw[i]),
            .deb  (deb[i]),
            .rise (rise[i]),
            .fall (fall[i])
        );
    end

    // EDGE_SEL only picks which pulse counts; flipping it never fabricates
    // an event because the pulses come from deb transitions alone.
    assign ev = (edge_sel_q & fall) | (~edge_sel_q & rise);

    // ---------------------------------------------------------------------
    // Bus decode
    // ---------------------------------------------------------------------
    logic [4:0]  word_off;
    logic        wr;
    logic [31:0] wmask;
    logic [31:0] wbits;
    logic [31:0] out32;
    logic        unused_addr_lsb;

    assign word_off        = {addr[4:2], 2'b00};
    assign unused_addr_lsb = ^addr[1:0];
    assign wr              = req && (we != 4'b0000);
    assign wmask           = byte_mask(we);
    assign wbits           = wdata & wmask;
    assign out32           = 32'(out_q);

    logic [31:0] rd_mux;

    always_comb begin
        rd_mux = '0;
        case (word_off)
            OFF_IN:       rd_mux = 32'(deb);
            OFF_OUT:      rd_mux = out32;
            OFF_IRQ_EN:   rd_mux = 32'(irq_en_q);
            OFF_EDGE_SEL: rd_mux = 32'(edge_sel_q);
            OFF_IRQ_STAT: rd_mux = 32'(irq_stat_q);
            default:      rd_mux = '0;
        endcase
    end

    // ---------------------------------------------------------------------
    // Register next-state
    // ---------------------------------------------------------------------
    logic [OUT_W-1:0] out_nxt;
    logic [IN_W-1:0]  irq_en_nxt;
    logic [IN_W-1:0]  edge_sel_nxt;
    logic [IN_W-1:0]  stat_clr;
    logic [IN_W-1:0]  irq_stat_nxt;

    always_comb begin
        out_nxt      = out_q;
        irq_en_nxt   = irq_en_q;
        edge_sel_nxt = edge_sel_q;
        stat_clr     = '0;
        if (wr) begin
            case (word_off)
                OFF_OUT:      out_nxt      = OUT_W'((out32 & ~wmask) | wbits);
                OFF_OUT_SET:  out_nxt      = OUT_W'(out32 | wbits);
                OFF_OUT_CLR:  out_nxt      = OUT_W'(out32 & ~wbits);
                OFF_IRQ_EN:   irq_en_nxt   = IN_W'((32'(irq_en_q) & ~wmask) | wbits);
                OFF_EDGE_SEL: edge_sel_nxt = IN_W'((32'(edge_sel_q) & ~wmask) | wbits);
                OFF_IRQ_STAT: stat_clr     = IN_W'(wbits);
                default:      ;
            endcase
        end
        // Clear first, then OR in new events so a coincident event survives.
        irq_stat_nxt = (irq_stat_q & ~stat_clr) | ev;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            out_q      <= '0;
            irq_en_q   <= '0;
            edge_sel_q <= '0;
            irq_stat_q <= '0;
            ready      <= 1'b0;
            rdata      <= '0;
        end else begin
            out_q      <= out_nxt;
            irq_en_q   <= irq_en_nxt;
            edge_sel_q <= edge_sel_nxt;
            irq_stat_q <= irq_stat_nxt;
            ready      <= req;
            // Read data is the pre-update register view; writes return 0.
            rdata      <= (req && !wr) ? rd_mux : '0;
        end
    end

    assign led = out_q;
    assign irq = |(irq_stat_q & irq_en_q);

endmodule
